// File: rtl/uart_pkt_decode.sv
// uart_pkt_decode: framed UART command decoder feeding sdram_top.
// Parses header/address/length/payload/XOR packets and drives one command trigger per packet.
//
// Ports:
//   sys_clk, sys_rst_n        clock, async active-low reset
//   uart_flag, uart_data      received byte strobe and data
//   wfifo_full                write FIFO full
//   cmd_ack                   command completed by sdram_top
//   wr_trig, rd_trig          one-cycle command pulses
//   cmd_addr, cmd_len         command address and burst length
//   wfifo_wr_en, wfifo_data   write FIFO push
//   wfifo_clr                 discard write FIFO contents
//   busy                      command outstanding
//   err_pulse, err_code       error strobe and last error code
module uart_pkt_decode #(
    parameter int D_WIDTH     = 8,
    parameter int ADDR_BYTES  = 3,
    parameter int MAX_LEN     = 16,
    parameter int LEN_WIDTH   = 5,
    parameter int TIMEOUT_CYC = 1_500_000
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    uart_flag,
    input  logic [D_WIDTH-1:0]      uart_data,
    input  logic                    wfifo_full,
    input  logic                    cmd_ack,
    output logic                    wr_trig,
    output logic                    rd_trig,
    output logic [8*ADDR_BYTES-1:0] cmd_addr,
    output logic [LEN_WIDTH-1:0]    cmd_len,
    output logic                    wfifo_wr_en,
    output logic [D_WIDTH-1:0]      wfifo_data,
    output logic                    wfifo_clr,
    output logic                    busy,
    output logic                    err_pulse,
    output logic [2:0]              err_code
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [D_WIDTH-1:0] HDR_WR    = D_WIDTH'(8'h55);
    localparam logic [D_WIDTH-1:0] HDR_RD    = D_WIDTH'(8'hAA);
    localparam logic [D_WIDTH-1:0] MAX_LEN_B = D_WIDTH'(MAX_LEN);
    localparam logic [D_WIDTH-1:0] ADDR_LAST = D_WIDTH'(ADDR_BYTES - 1);
    localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] E_LEN  = 3'd1;
    localparam logic [2:0] E_CSUM = 3'd2;
    localparam logic [2:0] E_TMO  = 3'd3;
    localparam logic [2:0] E_OVF  = 3'd4;
    localparam logic [2:0] E_OVR  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic                 is_wr_q, is_wr_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [D_WIDTH-1:0]   cnt_q, cnt_d;
    logic [D_WIDTH-1:0]   xor_q, xor_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 wr_trig_q, wr_trig_d;
    logic                 rd_trig_q, rd_trig_d;
    logic                 push_q, push_d;
    logic [D_WIDTH-1:0]   wdata_q, wdata_d;
    logic                 clr_q, clr_d;
    logic                 busy_q, busy_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [2:0]           err_code_q, err_code_d;
    logic                 running;

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        wr_trig_d   = 1'b0;
        rd_trig_d   = 1'b0;
        push_d      = 1'b0;
        wdata_d     = wdata_q;
        clr_d       = 1'b0;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;

        running = (state_q == S_ADDR) || (state_q == S_LEN) ||
                  (state_q == S_DATA) || (state_q == S_CSUM);
        // Any received byte restarts the inter-byte window.
        tmo_d = (uart_flag || !running) ? '0 : tmo_q + TW'(1);

        if (uart_flag) begin
            xor_d = xor_q ^ uart_data;
            unique case (state_q)
                S_IDLE: begin
                    if (uart_data == HDR_WR || uart_data == HDR_RD) begin
                        is_wr_d = (uart_data == HDR_WR);
                        xor_d   = uart_data;
                        cnt_d   = '0;
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_d = (addr_q << 8) | AW'(uart_data);
                    cnt_d  = cnt_q + D_WIDTH'(1);
                    if (cnt_q == ADDR_LAST) begin
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (uart_data == '0 || uart_data > MAX_LEN_B) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = E_LEN;
                        state_d     = S_IDLE;
                    end else begin
                        len_d   = uart_data[LEN_WIDTH-1:0];
                        cnt_d   = uart_data;
                        state_d = is_wr_q ? S_DATA : S_CSUM;
                    end
                end
                S_DATA: begin
                    if (wfifo_full) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = E_OVF;
                        clr_d       = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        push_d  = 1'b1;
                        wdata_d = uart_data;
                        cnt_d   = cnt_q - D_WIDTH'(1);
                        if (cnt_q == D_WIDTH'(1)) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (xor_q == uart_data) begin
                        wr_trig_d = is_wr_q;
                        rd_trig_d = !is_wr_q;
                        state_d   = S_WAIT;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = E_CSUM;
                        clr_d       = is_wr_q;
                        state_d     = S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Byte is dropped; a simultaneous ack still retires the command.
                    err_pulse_d = 1'b1;
                    err_code_d  = E_OVR;
                    if (cmd_ack) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_WAIT && cmd_ack) begin
            state_d = S_IDLE;
        end else if (running && tmo_q == TMO_LAST) begin
            err_pulse_d = 1'b1;
            err_code_d  = E_TMO;
            clr_d       = is_wr_q && (state_q == S_DATA || state_q == S_CSUM);
            state_d     = S_IDLE;
        end

        busy_d = (state_d == S_WAIT);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            xor_q       <= '0;
            tmo_q       <= '0;
            wr_trig_q   <= 1'b0;
            rd_trig_q   <= 1'b0;
            push_q      <= 1'b0;
            wdata_q     <= '0;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            tmo_q       <= tmo_d;
            wr_trig_q   <= wr_trig_d;
            rd_trig_q   <= rd_trig_d;
            push_q      <= push_d;
            wdata_q     <= wdata_d;
            clr_q       <= clr_d;
            busy_q      <= busy_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end

    assign wr_trig     = wr_trig_q;
    assign rd_trig     = rd_trig_q;
    assign cmd_addr    = addr_q;
    assign cmd_len     = len_q;
    assign wfifo_wr_en = push_q;
    assign wfifo_data  = wdata_q;
    assign wfifo_clr   = clr_q;
    assign busy        = busy_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_pkt_decode.sv
// tb_uart_pkt_decode: scoreboard bench for uart_pkt_decode.
// Expected pushes, commands and errors are queued at stimulus time and popped on DUT output.
module tb_uart_pkt_decode;

    localparam int TMO = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        uart_flag = 1'b0;
    logic [7:0]  uart_data = '0;
    logic        wfifo_full = 1'b0;
    logic        cmd_ack = 1'b0;
    logic        wr_trig, rd_trig;
    logic [23:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic        wfifo_wr_en;
    logic [7:0]  wfifo_data;
    logic        wfifo_clr, busy, err_pulse;
    logic [2:0]  err_code;

    uart_pkt_decode #(
        .TIMEOUT_CYC(TMO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_flag  (uart_flag),
        .uart_data  (uart_data),
        .wfifo_full (wfifo_full),
        .cmd_ack    (cmd_ack),
        .wr_trig    (wr_trig),
        .rd_trig    (rd_trig),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wfifo_wr_en(wfifo_wr_en),
        .wfifo_data (wfifo_data),
        .wfifo_clr  (wfifo_clr),
        .busy       (busy),
        .err_pulse  (err_pulse),
        .err_code   (err_code)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
        logic [4:0]  len;
    } cmd_t;

    typedef struct packed {
        logic [2:0] code;
        logic       clr;
    } err_t;

    typedef logic [7:0] bq_t[$];

    int   n_chk = 0;
    int   n_fail = 0;
    logic [7:0] push_q[$];
    cmd_t cmd_q[$];
    err_t err_q[$];
    cmd_t mc;
    err_t me;
    bq_t  dat;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (wfifo_wr_en) begin
                if (push_q.size() == 0) chk("push_unexp", 1, 0);
                else chk("push_data", wfifo_data, push_q.pop_front());
            end
            if (wr_trig || rd_trig) begin
                if (cmd_q.size() == 0) begin
                    chk("trig_unexp", 1, 0);
                end else begin
                    mc = cmd_q.pop_front();
                    chk("trig_wr", wr_trig, mc.wr);
                    chk("trig_rd", rd_trig, !mc.wr);
                    chk("cmd_addr", cmd_addr, mc.addr);
                    chk("cmd_len", cmd_len, mc.len);
                    chk("busy_rise", busy, 1);
                end
            end
            if (err_pulse) begin
                if (err_q.size() == 0) begin
                    chk("err_unexp", 1, 0);
                end else begin
                    me = err_q.pop_front();
                    chk("err_code", err_code, me.code);
                    chk("err_clr", wfifo_clr, me.clr);
                end
            end else if (wfifo_clr) begin
                chk("clr_unexp", 1, 0);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge sys_clk);
        uart_flag = 1'b1;
        uart_data = b;
        @(negedge sys_clk);
        uart_flag = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic send_pkt(input bit wr, input logic [23:0] addr,
                            input logic [7:0] len, input bq_t d,
                            input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        b = wr ? 8'h55 : 8'hAA;
        x = b;
        send(b);
        for (int i = 0; i < 3; i++) begin
            b = addr[23-8*i -: 8];
            x ^= b;
            send(b);
        end
        x ^= len;
        send(len);
        if (wr) begin
            foreach (d[i]) begin
                push_q.push_back(d[i]);
                x ^= d[i];
                send(d[i]);
            end
        end
        if (bad) begin
            err_q.push_back('{3'd2, wr});
            send(x ^ 8'hFF);
        end else begin
            cmd_q.push_back('{wr, addr, len[4:0]});
            send(x);
        end
    endtask

    task automatic wait_drain();
        int left;
        for (int i = 0; i < TMO + 100; i++) begin
            if (push_q.size() == 0 && cmd_q.size() == 0 && err_q.size() == 0)
                break;
            @(negedge sys_clk);
        end
        left = push_q.size() + cmd_q.size() + err_q.size();
        if (left != 0) begin
            chk("drain", left, 0);
            push_q.delete();
            cmd_q.delete();
            err_q.delete();
        end
    endtask

    task automatic do_ack(input logic [23:0] ea);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy) begin
                seen = 1;
                break;
            end
            @(negedge sys_clk);
        end
        if (!seen) chk("busy_wait", 0, 1);
        repeat (2) @(negedge sys_clk);
        chk("busy_hold", busy, 1);
        chk("addr_hold", cmd_addr, ea);
        cmd_ack = 1'b1;
        @(negedge sys_clk);
        cmd_ack = 1'b0;
        chk("busy_fall", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_wr_trig", wr_trig, 0);
        chk("rst_rd_trig", rd_trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", cmd_addr, 0);
        chk("rst_len", cmd_len, 0);
        chk("rst_err", err_code, 0);
        chk("rst_push", wfifo_wr_en, 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        dat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_pkt(1, 24'h000120, 8'd4, dat, 0);
        wait_drain();
        do_ack(24'h000120);

        dat = {};
        send_pkt(0, 24'h123456, 8'h10, dat, 0);
        wait_drain();
        do_ack(24'h123456);

        send(8'h00);
        send(8'hFF);
        dat = '{8'h5A, 8'h3C};
        send_pkt(1, 24'hABCDEF, 8'd2, dat, 0);
        wait_drain();
        do_ack(24'hABCDEF);

        send(8'h55);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        err_q.push_back('{3'd1, 1'b0});
        send(8'h00);
        wait_drain();
        send(8'hAA);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        err_q.push_back('{3'd1, 1'b0});
        send(8'h11);
        wait_drain();

        dat = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt(1, 24'h000040, 8'd4, dat, 1);
        wait_drain();
        chk("csum_err_code", err_code, 2);

        send(8'h55);
        send(8'h00);
        send(8'h00);
        send(8'h80);
        send(8'h04);
        push_q.push_back(8'hE1);
        send(8'hE1);
        push_q.push_back(8'hE2);
        send(8'hE2);
        err_q.push_back('{3'd3, 1'b1});
        wait_drain();
        chk("tmo_busy", busy, 0);

        send(8'h55);
        send(8'h00);
        send(8'h00);
        send(8'h10);
        send(8'h02);
        push_q.push_back(8'h11);
        send(8'h11);
        wfifo_full = 1'b1;
        err_q.push_back('{3'd4, 1'b1});
        send(8'h22);
        wfifo_full = 1'b0;
        wait_drain();

        dat = {};
        send_pkt(0, 24'h00BEEF, 8'd1, dat, 0);
        wait_drain();
        err_q.push_back('{3'd5, 1'b0});
        send(8'h77);
        wait_drain();
        chk("ovr_busy", busy, 1);
        do_ack(24'h00BEEF);

        send_pkt(0, 24'h0F0F0F, 8'd8, dat, 0);
        wait_drain();
        repeat (2) @(negedge sys_clk);
        err_q.push_back('{3'd5, 1'b0});
        cmd_ack = 1'b1;
        uart_flag = 1'b1;
        uart_data = 8'h55;
        @(negedge sys_clk);
        cmd_ack = 1'b0;
        uart_flag = 1'b0;
        chk("ackovr_busy", busy, 0);
        wait_drain();
        dat = '{8'h99};
        send_pkt(1, 24'h777777, 8'd1, dat, 0);
        wait_drain();
        do_ack(24'h777777);

        send(8'h55);
        send(8'h12);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_code, 0);
        chk("mid_rst_addr", cmd_addr, 0);
        chk("mid_rst_clr", wfifo_clr, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        dat = {};
        send_pkt(0, 24'h345678, 8'd3, dat, 0);
        wait_drain();
        do_ack(24'h345678);

        repeat (5) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
